fpga_robots_game_ps2_rx: RTL and testbench

- PS/2 keyboard receive front end. Samples the raw PS/2 clock and data pins and deserialises device-to-host frames (start, 8 data bits LSB first, odd parity, stop).
- Validates each frame and emits one byte per frame as a single-cycle strobe.
- Sits directly upstream of the game control block. Its ps2_rx_dat/ps2_rx_stb outputs connect one-to-one to that block's inputs of the same names.
- Receive only; this block never drives the PS/2 lines.

---
 rtl/fpga_robots_game_ps2_rx.sv | 179 +++++++++++++++++
 tb/tb_fpga_robots_game_ps2_rx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_robots_game_ps2_rx.sv
// PS/2 keyboard receive front end: synchronises the PS/2 pins, deserialises 11-bit
// device-to-host frames and emits validated bytes. Optional clock filter: PS2_RX_FILTER_EN.
module fpga_robots_game_ps2_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned FILT_LEN       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic [7:0] ps2_rx_dat,
    output logic       ps2_rx_stb,
    output logic       ps2_rx_err,
    output logic       ps2_busy
);

    localparam logic [16:0] TO_LAST = 17'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    if (FILT_LEN < 2) begin : g_filt_len_check
        $error("FILT_LEN must be at least 2");
    end

    logic        r_clk_s0, r_clk_s1;
    logic        r_dat_s0, r_dat_s1;
    logic        r_clk_prev;
    logic        r_fall;
    logic        r_dat_smp;
    logic        w_clk_lvl;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_shreg, w_shreg_nxt;
    logic [3:0]  r_bitcnt, w_bitcnt_nxt;
    logic        r_par, w_par_nxt;
    logic [16:0] r_to, w_to_nxt;
    logic [7:0]  r_rx_dat, w_rx_dat_nxt;
    logic        r_stb, w_stb_nxt;
    logic        r_err, w_err_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_clk_s0 <= 1'b1;
            r_clk_s1 <= 1'b1;
            r_dat_s0 <= 1'b1;
            r_dat_s1 <= 1'b1;
        end else begin
            r_clk_s0 <= ps2_clk_in;
            r_clk_s1 <= r_clk_s0;
            r_dat_s0 <= ps2_dat_in;
            r_dat_s1 <= r_dat_s0;
        end
    end

`ifdef PS2_RX_FILTER_EN
    // Filtered level only moves once the whole window agrees, so short pulses are dropped.
    logic [FILT_LEN-1:0] r_filt;
    logic                r_clk_filt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_filt     <= '1;
            r_clk_filt <= 1'b1;
        end else begin
            r_filt <= {r_filt[FILT_LEN-2:0], r_clk_s1};
            if (&r_filt) begin
                r_clk_filt <= 1'b1;
            end else if (~|r_filt) begin
                r_clk_filt <= 1'b0;
            end
        end
    end

    assign w_clk_lvl = r_clk_filt;
`else
    assign w_clk_lvl = r_clk_s1;
`endif

    // Edge strobe and its data sample are registered together so the FSM sees a matched pair.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_clk_prev <= 1'b1;
            r_fall     <= 1'b0;
            r_dat_smp  <= 1'b1;
        end else begin
            r_clk_prev <= w_clk_lvl;
            r_fall     <= r_clk_prev & ~w_clk_lvl;
            r_dat_smp  <= r_dat_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_par    <= 1'b0;
            r_to     <= '0;
            r_rx_dat <= '0;
            r_stb    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shreg  <= w_shreg_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_par    <= w_par_nxt;
            r_to     <= w_to_nxt;
            r_rx_dat <= w_rx_dat_nxt;
            r_stb    <= w_stb_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shreg_nxt  = r_shreg;
        w_bitcnt_nxt = r_bitcnt;
        w_par_nxt    = r_par;
        w_to_nxt     = '0;
        w_rx_dat_nxt = r_rx_dat;
        w_stb_nxt    = 1'b0;
        w_err_nxt    = 1'b0;

        if (r_state != S_IDLE) begin
            w_to_nxt = r_to + 17'd1;
        end

        // An edge outranks the timeout terminal count in the same cycle.
        if (r_fall) begin
            w_to_nxt = '0;
            unique case (r_state)
                S_IDLE: begin
                    if (!r_dat_smp) begin
                        w_state_nxt  = S_DATA;
                        w_bitcnt_nxt = '0;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                S_DATA: begin
                    w_shreg_nxt  = {r_dat_smp, r_shreg[7:1]};
                    w_bitcnt_nxt = r_bitcnt + 4'd1;
                    if (r_bitcnt == 4'd7) begin
                        w_state_nxt = S_PARITY;
                    end
                end
                S_PARITY: begin
                    w_par_nxt   = r_dat_smp;
                    w_state_nxt = S_STOP;
                end
                S_STOP: begin
                    if (((^r_shreg) ^ r_par) && r_dat_smp) begin
                        w_rx_dat_nxt = r_shreg;
                        w_stb_nxt    = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end else if (r_state != S_IDLE && r_to == TO_LAST) begin
            w_state_nxt = S_IDLE;
            w_err_nxt   = 1'b1;
            w_to_nxt    = '0;
        end
    end

    assign ps2_rx_dat = r_rx_dat;
    assign ps2_rx_stb = r_stb;
    assign ps2_rx_err = r_err;
    assign ps2_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_fpga_robots_game_ps2_rx.sv
// Directed bench for fpga_robots_game_ps2_rx: frame-level model of expected bytes/errors
// with their arrival cycles, checked every cycle, plus literal spot checks.
module tb_fpga_robots_game_ps2_rx;

    localparam int unsigned TO   = 1000;
    localparam int unsigned HALF = 100;

    logic       clk        = 1'b0;
    logic       rst        = 1'b0;
    logic       ps2_clk_in = 1'b1;
    logic       ps2_dat_in = 1'b1;
    logic [7:0] ps2_rx_dat;
    logic       ps2_rx_stb;
    logic       ps2_rx_err;
    logic       ps2_busy;

    fpga_robots_game_ps2_rx #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_rx_dat (ps2_rx_dat),
        .ps2_rx_stb (ps2_rx_stb),
        .ps2_rx_err (ps2_rx_err),
        .ps2_busy   (ps2_busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc      = 0;
    logic        rst_seen = 1'b0;
    logic        armed    = 1'b0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
        armed    <= 1'b1;
    end

    typedef struct {
        logic        is_err;
        logic [7:0]  dat;
        int unsigned at;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] model_dat = 8'h00;
    int         checks    = 0;
    int         failures  = 0;

    task automatic expect_ev(input logic is_err, input logic [7:0] d, input int unsigned at);
        ev_t e;
        e.is_err = is_err;
        e.dat    = d;
        e.at     = at;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h (cyc %0d)", name, got, req, cyc);
        end
    endtask

    task automatic compare_loop();
        ev_t e;
        forever begin
            @(negedge clk);
            if (armed) begin
                if (!rst_seen) begin
                    model_dat = 8'h00;
                    checks++;
                    if (ps2_rx_dat !== 8'h00 || ps2_rx_stb !== 1'b0 ||
                        ps2_rx_err !== 1'b0 || ps2_busy !== 1'b0) begin
                        failures++;
                        $display("FAIL reset_state: dat=%h stb=%b err=%b busy=%b required 00 0 0 0 (cyc %0d)",
                                 ps2_rx_dat, ps2_rx_stb, ps2_rx_err, ps2_busy, cyc);
                    end
                end else begin
                    if (exp_q.size() > 0 && cyc > exp_q[0].at) begin
                        failures++;
                        e = exp_q.pop_front();
                        $display("FAIL missing_event: nothing seen, required err=%b dat=%h at cyc %0d (now %0d)",
                                 e.is_err, e.dat, e.at, cyc);
                    end
                    checks++;
                    if (ps2_rx_stb === 1'b1 && ps2_rx_err === 1'b1) begin
                        failures++;
                        $display("FAIL stb_err_exclusive: stb=1 err=1 required not both (cyc %0d)", cyc);
                    end
                    if (ps2_rx_stb !== 1'b0 || ps2_rx_err !== 1'b0) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            failures++;
                            $display("FAIL unexpected_event: stb=%b err=%b dat=%h required no event (cyc %0d)",
                                     ps2_rx_stb, ps2_rx_err, ps2_rx_dat, cyc);
                        end else begin
                            e = exp_q.pop_front();
                            if (e.is_err !== ps2_rx_err || e.at != cyc ||
                                (!e.is_err && ps2_rx_dat !== e.dat)) begin
                                failures++;
                                $display("FAIL event: err=%b dat=%h cyc=%0d required err=%b dat=%h cyc=%0d",
                                         ps2_rx_err, ps2_rx_dat, cyc, e.is_err, e.dat, e.at);
                            end
                            if (!e.is_err) model_dat = e.dat;
                        end
                    end
                    checks++;
                    if (ps2_rx_dat !== model_dat) begin
                        failures++;
                        $display("FAIL rx_dat_hold: got %h required %h (cyc %0d)", ps2_rx_dat, model_dat, cyc);
                    end
                end
            end
        end
    endtask

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_fall(input logic b, output int unsigned fc);
        ps2_dat_in = b;
        wait_cyc(HALF / 2);
        ps2_clk_in = 1'b0;
        fc = cyc;
    endtask

    task automatic bit_rise();
        wait_cyc(HALF);
        ps2_clk_in = 1'b1;
        wait_cyc(HALF / 2);
    endtask

    // Frame good iff odd parity over data+parity and stop bit high; outcome 4 clk after stop fall.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        int unsigned fc;
        bit_fall(1'b0, fc);
        bit_rise();
        for (int i = 0; i < 8; i++) begin
            bit_fall(d[i], fc);
            bit_rise();
        end
        bit_fall(par, fc);
        bit_rise();
        bit_fall(stop, fc);
        if ((((^d) ^ par) == 1'b1) && stop) expect_ev(1'b0, d, fc + 4);
        else                                 expect_ev(1'b1, 8'h00, fc + 4);
        bit_rise();
        ps2_dat_in = 1'b1;
        wait_cyc(20);
    endtask

    task automatic send_partial(input logic [7:0] d, input int unsigned n, output int unsigned fc);
        bit_fall(1'b0, fc);
        bit_rise();
        for (int i = 0; i < 8; i++) begin
            if (i < int'(n)) begin
                bit_fall(d[i], fc);
                bit_rise();
            end
        end
    endtask

    initial begin
        int unsigned fc;
        fork
            compare_loop();
        join_none

        rst = 1'b0;
        wait_cyc(4);
        chk("reset_dat", ps2_rx_dat, 8'h00);
        chk("reset_busy", {7'd0, ps2_busy}, 8'h00);
        rst = 1'b1;
        wait_cyc(10);

        send_frame(8'h1C, 1'b0, 1'b1);
        chk("good_1C", ps2_rx_dat, 8'h1C);
        chk("busy_after_1C", {7'd0, ps2_busy}, 8'h00);
        send_frame(8'hF0, 1'b1, 1'b1);
        chk("good_F0", ps2_rx_dat, 8'hF0);

        send_frame(8'h1C, 1'b1, 1'b1);
        chk("bad_parity_hold", ps2_rx_dat, 8'hF0);

        send_frame(8'hE0, 1'b0, 1'b0);
        chk("bad_stop_hold", ps2_rx_dat, 8'hF0);
        send_frame(8'hE0, 1'b0, 1'b1);
        chk("good_E0", ps2_rx_dat, 8'hE0);

        send_partial(8'h75, 3, fc);
        chk("busy_mid_frame", {7'd0, ps2_busy}, 8'h01);
        expect_ev(1'b1, 8'h00, fc + 4 + TO);
        ps2_dat_in = 1'b1;
        wait_cyc(TO + 100);
        chk("busy_after_timeout", {7'd0, ps2_busy}, 8'h00);
        send_frame(8'h75, 1'b0, 1'b1);
        chk("good_75", ps2_rx_dat, 8'h75);

        send_partial(8'h1C, 4, fc);
        ps2_dat_in = 1'b1;
        rst = 1'b0;
        wait_cyc(2);
        rst = 1'b1;
        wait_cyc(5);
        chk("midreset_dat", ps2_rx_dat, 8'h00);
        chk("midreset_busy", {7'd0, ps2_busy}, 8'h00);
        wait_cyc(100);
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("after_reset_1C", ps2_rx_dat, 8'h1C);

        ps2_dat_in = 1'b1;
        ps2_clk_in = 1'b0;
        fc = cyc;
`ifndef PS2_RX_FILTER_EN
        expect_ev(1'b1, 8'h00, fc + 4);
`endif
        wait_cyc(3);
        ps2_clk_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wait_cyc(1);
            chk("glitch_busy", {7'd0, ps2_busy}, 8'h00);
        end

        wait_cyc(30);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_events: %0d outstanding, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
